// File: rtl/mac_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// mac_sequencer_pkg
// Shared types and constants for the MAC sequencer:
//   - layer_e : job type encoding carried on the layer input
//   - state_e : sequencer FSM states
//   - default tap counts for convolution and fully-connected layers
//   - operand, result, address, index and accumulator widths
// -----------------------------------------------------------------------------
package mac_sequencer_pkg;

    localparam int TAPS_CONV_DEF = 25;
    localparam int TAPS_FC_DEF   = 192;

    localparam int ACC_W  = 40;
    localparam int OPND_W = 16;
    localparam int RES_W  = 32;
    localparam int ADDR_W = 16;
    localparam int IDX_W  = 10;

    typedef enum logic [1:0] {
        LAYER_CONV1   = 2'b00,
        LAYER_CONV2   = 2'b01,
        LAYER_FC      = 2'b10,
        LAYER_ILLEGAL = 2'b11
    } layer_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_EMIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/mac_sequencer_accum.sv
// -----------------------------------------------------------------------------
// mac_accum
// Signed multiply, 40-bit accumulate and 32-bit saturation.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset (zeros the accumulator)
//   clear        : zero the accumulator on the next edge (wins over acc_en)
//   acc_en       : add a*b to the accumulator on the next edge
//   a, b         : signed operands
//   sat_out      : accumulator saturated to the signed 32-bit range
// -----------------------------------------------------------------------------
module mac_accum
    import mac_sequencer_pkg::*;
#(
    parameter int DATA_W = OPND_W,
    parameter int COEF_W = OPND_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [RES_W-1:0]  sat_out
);

    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

    function automatic logic signed [RES_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            saturate = {1'b0, {(RES_W-1){1'b1}}};
        else if (v < SAT_MIN)
            saturate = {1'b1, {(RES_W-1){1'b0}}};
        else
            saturate = v[RES_W-1:0];
    endfunction

    logic signed [PROD_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]  acc_p1;

    // Stage 0: full-precision signed product of the operands returned by memory
    assign prod_p0 = PROD_W'(a) * PROD_W'(b);

    // Stage 1: sign-extended accumulate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            acc_p1 <= '0;
        else if (clear)
            acc_p1 <= '0;
        else if (acc_en)
            acc_p1 <= acc_p1 + ACC_W'(prod_p0);
    end

    assign sat_out = saturate(acc_p1);

endmodule

// File: rtl/mac_sequencer.sv
// -----------------------------------------------------------------------------
// mac_sequencer
// Runs dot-product jobs: for each output it reads T operand pairs, accumulates
// their products and presents the saturated result on a valid/ready port.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, layer,
//   num_outputs          : job request (sampled only while idle)
//   busy, done, err      : job status; done and err are one-cycle pulses
//   rd_en, a_addr, b_addr: operand read request
//   a_data, b_data       : signed operands, valid the cycle after rd_en
//   out_valid, out_ready,
//   out_data, out_idx    : result handshake
// -----------------------------------------------------------------------------
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int TAPS_CONV = TAPS_CONV_DEF,
    parameter int TAPS_FC   = TAPS_FC_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [1:0]               layer,
    input  logic [IDX_W-1:0]         num_outputs,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        a_addr,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic signed [OPND_W-1:0] a_data,
    input  logic signed [OPND_W-1:0] b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [RES_W-1:0]  out_data,
    output logic [IDX_W-1:0]         out_idx
);

    localparam logic [ADDR_W-1:0] T_CONV = ADDR_W'(TAPS_CONV);
    localparam logic [ADDR_W-1:0] T_FC   = ADDR_W'(TAPS_FC);

    state_e            state, state_nx;
    layer_e            layer_q;
    logic [IDX_W-1:0]  num_q;
    logic [ADDR_W-1:0] tap;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] taps;
    logic              rd_en_p1;
    logic              err_q;
    logic              clear;
    logic              accept;
    logic              tap_last;
    logic              emit_last;

    assign taps      = (layer_q == LAYER_FC) ? T_FC : T_CONV;
    assign accept    = (state == S_IDLE) && start && (layer != LAYER_ILLEGAL);
    assign tap_last  = (tap == taps - 1'b1);
    assign emit_last = (out_idx == num_q - 1'b1);

    // base tracks out_idx*T incrementally, so the modulo-2^16 wrap is free
    assign a_addr = (layer_q == LAYER_FC) ? tap : base + tap;
    assign b_addr = (layer_q == LAYER_FC) ? base + tap : tap;
    assign err    = err_q;

    always_comb begin
        state_nx  = state;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        clear     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (num_outputs == '0) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RUN;
                        clear    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (tap_last)
                    state_nx = S_LAST;
            end
            S_LAST: begin
                busy     = 1'b1;
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (emit_last) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_RUN;
                        clear    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            layer_q  <= LAYER_CONV1;
            num_q    <= '0;
            out_idx  <= '0;
            tap      <= '0;
            base     <= '0;
            rd_en_p1 <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            rd_en_p1 <= rd_en;
            err_q    <= (state == S_IDLE) && start && (layer == LAYER_ILLEGAL);
            if (accept) begin
                layer_q <= layer_e'(layer);
                num_q   <= num_outputs;
                out_idx <= '0;
                base    <= '0;
                tap     <= '0;
            end
            if (state == S_RUN)
                tap <= tap_last ? '0 : tap + 1'b1;
            if ((state == S_EMIT) && out_ready && !emit_last) begin
                out_idx <= out_idx + 1'b1;
                base    <= base + taps;
            end
        end
    end

    // Operands arrive one cycle after rd_en, so accumulation trails the read
    // strobe by one cycle; the LAST state exists to absorb the final product.
    mac_accum #(
        .DATA_W (OPND_W),
        .COEF_W (OPND_W)
    ) u_mac_accum (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .acc_en  (rd_en_p1),
        .a       (a_data),
        .b       (b_data),
        .sat_out (out_data)
    );

endmodule

// File: tb/tb_mac_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mac_sequencer
// Self-checking bench for mac_sequencer: operand memories, a dot-product
// reference model computed from the addressing rules, and directed plus
// randomized jobs.
// -----------------------------------------------------------------------------
module tb_mac_sequencer;

    localparam int TC = 25;
    localparam int TF = 192;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic [1:0]         layer = 2'b00;
    logic [9:0]         num_outputs = '0;
    logic               busy, done, err, rd_en;
    logic [15:0]        a_addr, b_addr;
    logic signed [15:0] a_data = '0;
    logic signed [15:0] b_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_data;
    logic [9:0]         out_idx;

    logic signed [15:0] a_mem [0:65535];
    logic signed [15:0] b_mem [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mac_sequencer #(.TAPS_CONV(TC), .TAPS_FC(TF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .layer       (layer),
        .num_outputs (num_outputs),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .rd_en       (rd_en),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .a_data      (a_data),
        .b_data      (b_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx)
    );

    // Operand memory: one-cycle read latency, junk on the bus when not read
    always @(posedge clk) begin
        if (rd_en) begin
            a_data <= a_mem[a_addr];
            b_data <= b_mem[b_addr];
        end else begin
            a_data <= 16'($urandom);
            b_data <= 16'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    endtask

    task automatic fill_const(input logic signed [15:0] av, input logic signed [15:0] bv);
        for (int j = 0; j < 65536; j++) begin
            a_mem[j] = av;
            b_mem[j] = bv;
        end
    endtask

    task automatic fill_rand();
        for (int j = 0; j < 65536; j++) begin
            a_mem[j] = 16'($urandom);
            b_mem[j] = 16'($urandom);
        end
    endtask

    function automatic int taps_of(input logic [1:0] lay);
        return (lay == 2'b10) ? TF : TC;
    endfunction

    function automatic logic [15:0] exp_a(input logic [1:0] lay, input int i, input int k);
        if (lay == 2'b10) return 16'(k);
        return 16'(i * taps_of(lay) + k);
    endfunction

    function automatic logic [15:0] exp_b(input logic [1:0] lay, input int i, input int k);
        if (lay == 2'b10) return 16'(i * taps_of(lay) + k);
        return 16'(k);
    endfunction

    function automatic logic signed [31:0] exp_out(input logic [1:0] lay, input int i);
        longint s = 0;
        for (int k = 0; k < taps_of(lay); k++)
            s += longint'(a_mem[exp_a(lay, i, k)]) * longint'(b_mem[exp_b(lay, i, k)]);
        if (s > SMAX) return 32'sh7fffffff;
        if (s < SMIN) return 32'sh80000000;
        return 32'(s);
    endfunction

    // Runs one job from the start pulse to done, checking every read and result.
    task automatic run_job(input logic [1:0] lay, input int num, input bit rnd_ready,
                           input int stall_out, input bit poke,
                           output logic signed [31:0] last_out);
        int T = taps_of(lay);
        int i = 0, k = 0, reads = 0, stalls = 0, hold = 0, cyc;
        bit fin = 0;
        logic signed [31:0] expv;
        last_out    = '0;
        layer       = lay;
        num_outputs = 10'(num);
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        expv  = (num > 0) ? exp_out(lay, 0) : 32'sd0;
        while (!fin && cyc < 4000) begin
            if (done) begin
                chk("done_cycle", 64'(cyc), 64'(1 + num * (T + 2) + stalls));
                chk("outputs_emitted", 64'(i), 64'(num));
                chk("total_reads", 64'(reads), 64'(num * T));
                chk("busy_at_done", busy, 1'b0);
                fin = 1;
            end else begin
                if (rd_en) begin
                    chk("a_addr", a_addr, exp_a(lay, i, k));
                    chk("b_addr", b_addr, exp_b(lay, i, k));
                    chk("busy_run", busy, 1'b1);
                    k++;
                    reads++;
                end
                if (out_valid) begin
                    chk("rd_en_in_emit", rd_en, 1'b0);
                    chk("reads_per_output", 64'(k), 64'(T));
                    chk("out_idx", out_idx, 10'(i));
                    chk("out_data", out_data, expv);
                    chk("err_in_job", err, 1'b0);
                    if (i == stall_out && hold < 5) begin
                        out_ready = 1'b0;
                        hold++;
                    end else if (rnd_ready) begin
                        out_ready = 1'($urandom_range(0, 1));
                    end else begin
                        out_ready = 1'b1;
                    end
                    if (out_ready) begin
                        last_out = out_data;
                        i++;
                        k = 0;
                        if (i < num) expv = exp_out(lay, i);
                    end else begin
                        stalls++;
                    end
                end else begin
                    out_ready = 1'b1;
                end
                // A start request while busy must have no effect on the job
                if (poke && cyc == 3) begin
                    start       = 1'b1;
                    layer       = (lay == 2'b10) ? 2'b00 : 2'b10;
                    num_outputs = ~10'(num);
                end else begin
                    start = 1'b0;
                end
            end
            if (!fin) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!fin) chk("job_timeout", 1'b0, 1'b1);
        out_ready = 1'b1;
        start     = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_rd_en"}, rd_en, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_data"}, out_data, 32'sd0);
        chk({tag, "_out_idx"}, out_idx, 10'd0);
        chk({tag, "_a_addr"}, a_addr, 16'd0);
        chk({tag, "_b_addr"}, b_addr, 16'd0);
    endtask

    initial begin
        logic signed [31:0] res;
        logic [1:0] lay;
        int num;
        bit found;

        fill_const(16'sd0, 16'sd0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Conv1, two outputs, constant operands 1 and 2
        fill_const(16'sd1, 16'sd2);
        run_job(2'b00, 2, 1'b0, -1, 1'b0, res);
        chk("conv1_result", res, 32'sd50);

        // FC with positive saturation
        fill_const(16'sd32767, 16'sd32767);
        run_job(2'b10, 1, 1'b0, -1, 1'b0, res);
        chk("fc_sat_pos", res, 32'sh7fffffff);

        // FC with negative saturation
        fill_const(-16'sd32768, 16'sd32767);
        run_job(2'b10, 1, 1'b0, -1, 1'b0, res);
        chk("fc_sat_neg", res, 32'sh80000000);

        // Back-pressure: 5 stall cycles on the second output
        fill_rand();
        run_job(2'b01, 3, 1'b0, 1, 1'b0, res);

        // Illegal layer: err pulse only
        layer       = 2'b11;
        num_outputs = 10'd4;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        @(posedge clk); #1;
        chk("err_cleared", err, 1'b0);
        chk("err_no_busy", busy, 1'b0);
        chk("err_no_read", rd_en, 1'b0);

        // Empty job: done on the cycle after start, no reads
        run_job(2'b00, 0, 1'b0, -1, 1'b0, res);

        // Randomized jobs with random back-pressure and ignored start requests
        for (int r = 0; r < 6; r++) begin
            fill_rand();
            lay = 2'($urandom_range(0, 2));
            num = (lay == 2'b10) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 10));
            run_job(lay, num, 1'b1, -1, 1'b1, res);
        end

        // Reset in the middle of a conv job at tap 10
        fill_rand();
        layer       = 2'b00;
        num_outputs = 10'd3;
        start       = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (rd_en && a_addr == 16'd10) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("reach_tap10", found, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midjob_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        found = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy || rd_en) found = 1;
        end
        chk("abandoned_job_quiet", found, 1'b0);
        run_job(2'b00, 2, 1'b0, -1, 1'b0, res);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
